// File: rtl/mul_div_unit_pkg.sv
// Shared constants, bus types and small helpers for the multiply/divide unit.
package mul_div_unit_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [31:0] data_bus_t;
    typedef logic [63:0] double_data_bus_t;

    // Function codes handled by the unit (SPECIAL opcode space).
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // True for the four multi-cycle operations.
    function automatic logic is_mul_div(input logic [5:0] f);
        logic r;
        case (f)
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the signed multi-cycle operations.
    function automatic logic is_signed_op(input logic [5:0] f);
        logic r;
        case (f)
            FUNCT_MULT, FUNCT_DIV: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the divide operations.
    function automatic logic is_div_op(input logic [5:0] f);
        logic r;
        case (f)
            FUNCT_DIV, FUNCT_DIVU: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic data_bus_t abs32(input data_bus_t x);
        data_bus_t r;
        if (x[31]) begin
            r = (~x) + 32'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Datapath of the iterative multiplier/divider: a 64-bit shift register,
// a latched 32-bit operand and one shared 33-bit adder/subtractor.
// step_val is the register contents after one more step, so the owner can
// capture the final result on the same edge as the last iteration.
module mul_div_iter
    import mul_div_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  data_bus_t        op_a,
    input  data_bus_t        op_b,
    output double_data_bus_t step_val
);

    double_data_bus_t acc_r;
    data_bus_t        opnd_r;
    logic             div_r;
    logic [32:0]      add_a_s;
    logic [32:0]      add_b_s;
    logic [32:0]      sum_s;

    // Shared adder: multiply adds the multiplicand to the upper half, divide
    // subtracts the divisor from the upper half shifted left by one.
    always_comb begin
        add_a_s = 33'd0;
        add_b_s = 33'd0;
        sum_s   = 33'd0;
        if (div_r) begin
            add_a_s = acc_r[63:31];
            add_b_s = ~{1'b0, opnd_r};
            sum_s   = add_a_s + add_b_s + 33'd1;
        end else begin
            add_a_s = {1'b0, acc_r[63:32]};
            add_b_s = {1'b0, opnd_r};
            sum_s   = add_a_s + add_b_s;
        end
    end

    // Step logic: shift-add for multiply, restoring step for divide.
    always_comb begin
        step_val = acc_r;
        if (div_r) begin
            if (sum_s[32]) begin
                step_val = {acc_r[62:0], 1'b0};
            end else begin
                step_val = {sum_s[31:0], acc_r[30:0], 1'b1};
            end
        end else begin
            if (acc_r[0]) begin
                step_val = {sum_s, acc_r[31:1]};
            end else begin
                step_val = {1'b0, acc_r[63:1]};
            end
        end
    end

    // Operand load and per-cycle iteration of the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= 64'd0;
            opnd_r <= 32'd0;
            div_r  <= 1'b0;
        end else if (load) begin
            div_r <= mode_div;
            if (mode_div) begin
                acc_r  <= {32'd0, op_a};
                opnd_r <= op_b;
            end else begin
                acc_r  <= {32'd0, op_b};
                opnd_r <= op_a;
            end
        end else if (step) begin
            acc_r <= step_val;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 stall cycles; MFHI/MFLO/MTHI/MTLO are single cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        flush,
    output logic        stall_request,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [4:0]       cnt_r;
    data_bus_t        hi_r;
    data_bus_t        lo_r;
    logic             neg_main_r;
    logic             neg_rem_r;
    logic             div_zero_r;
    logic             mode_div_r;
    data_bus_t        dividend_raw_r;

    logic             start_s;
    logic             step_s;
    logic             finish_s;
    logic             signed_op_s;
    logic             div_op_s;
    data_bus_t        op_a_s;
    data_bus_t        op_b_s;
    double_data_bus_t step_val_s;
    double_data_bus_t prod_s;
    data_bus_t        quot_s;
    data_bus_t        rem_s;
    data_bus_t        hi_new_s;
    data_bus_t        lo_new_s;

    // Decode of the incoming instruction and operand magnitudes.
    always_comb begin
        signed_op_s = is_signed_op(funct);
        div_op_s    = is_div_op(funct);
        start_s     = (state_r == ST_IDLE) && is_mul_div(funct) && !flush;
        step_s      = (state_r == ST_BUSY) && !flush;
        finish_s    = step_s && (cnt_r == 5'd0);
        if (signed_op_s) begin
            op_a_s = abs32(operand_1);
            op_b_s = abs32(operand_2);
        end else begin
            op_a_s = operand_1;
            op_b_s = operand_2;
        end
    end

    mul_div_iter u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (start_s),
        .step     (step_s),
        .mode_div (div_op_s),
        .op_a     (op_a_s),
        .op_b     (op_b_s),
        .step_val (step_val_s)
    );

    // Sign fix-up of the final iteration and the divide-by-zero override.
    always_comb begin
        prod_s   = step_val_s;
        quot_s   = step_val_s[31:0];
        rem_s    = step_val_s[63:32];
        hi_new_s = 32'd0;
        lo_new_s = 32'd0;
        if (neg_main_r) begin
            prod_s = (~step_val_s) + 64'd1;
            quot_s = (~step_val_s[31:0]) + 32'd1;
        end else begin
            prod_s = step_val_s;
            quot_s = step_val_s[31:0];
        end
        if (neg_rem_r) begin
            rem_s = (~step_val_s[63:32]) + 32'd1;
        end else begin
            rem_s = step_val_s[63:32];
        end
        if (!mode_div_r) begin
            hi_new_s = prod_s[63:32];
            lo_new_s = prod_s[31:0];
        end else if (div_zero_r) begin
            hi_new_s = dividend_raw_r;
            lo_new_s = 32'hFFFF_FFFF;
        end else begin
            hi_new_s = rem_s;
            lo_new_s = quot_s;
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_next_s = ST_BUSY;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == 5'd0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
                ST_DONE: state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State, iteration counter and latched sign/zero flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 5'd0;
            neg_main_r     <= 1'b0;
            neg_rem_r      <= 1'b0;
            div_zero_r     <= 1'b0;
            mode_div_r     <= 1'b0;
            dividend_raw_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (start_s) begin
                cnt_r          <= 5'd31;
                neg_main_r     <= signed_op_s && (operand_1[31] ^ operand_2[31]);
                neg_rem_r      <= signed_op_s && div_op_s && operand_1[31];
                div_zero_r     <= div_op_s && (operand_2 == 32'd0);
                mode_div_r     <= div_op_s;
                dividend_raw_r <= operand_1;
            end else if (step_s && (cnt_r != 5'd0)) begin
                cnt_r <= cnt_r - 5'd1;
            end else if (flush) begin
                cnt_r <= 5'd0;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Architectural HI/LO: final mul/div result or MTHI/MTLO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (flush) begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end else if (finish_s) begin
            hi_r <= hi_new_s;
            lo_r <= lo_new_s;
        end else if ((state_r == ST_IDLE) && (funct == FUNCT_MTHI)) begin
            hi_r <= operand_1;
        end else if ((state_r == ST_IDLE) && (funct == FUNCT_MTLO)) begin
            lo_r <= operand_1;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Pipeline hold request and MFHI/MFLO read port.
    always_comb begin
        stall_request = !rst && (start_s || step_s);
        case (funct)
            FUNCT_MFHI: result = hi_r;
            FUNCT_MFLO: result = lo_r;
            default:    result = 32'd0;
        endcase
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        stall_request;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .funct         (funct),
        .operand_1     (operand_1),
        .operand_2     (operand_2),
        .flush         (flush),
        .stall_request (stall_request),
        .result        (result),
        .hi            (hi),
        .lo            (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one multi-cycle op; check 33 stall cycles and the HI/LO result in DONE.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int stalls;
        funct = f; operand_1 = a; operand_2 = b;
        #1;
        stalls = stall_request ? 1 : 0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (stall_request) stalls++;
        end
        @(posedge clk); #1;
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
        chk({tag, "_done_stall"}, {31'd0, stall_request}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_result0"}, result, 32'd0);
        funct = 6'd0; operand_1 = 32'd0; operand_2 = 32'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; funct = 6'd0; operand_1 = 32'd0; operand_2 = 32'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_stall", {31'd0, stall_request}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // MFLO/MFHI right after MULT: zero latency, no stall.
        funct = FUNCT_MFLO; #1;
        chk("mflo_result", result, 32'hFFFF_FFEB);
        chk("mflo_stall", {31'd0, stall_request}, 32'd0);
        funct = FUNCT_MFHI; #1;
        chk("mfhi_result", result, 32'hFFFF_FFFF);
        funct = 6'd0;
        @(posedge clk); #1;

        run_op("mult_negneg", FUNCT_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6);
        run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("divu_norm", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_by0s", FUNCT_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("divu_by0", FUNCT_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);

        // MTHI, then MULT aborted by flush at BUSY cycle 10.
        funct = FUNCT_MTHI; operand_1 = 32'h0000_1234; #1;
        chk("mthi_stall", {31'd0, stall_request}, 32'd0);
        @(posedge clk); #1;
        chk("mthi_hi", hi, 32'h0000_1234);
        funct = FUNCT_MULT; operand_1 = 32'd5; operand_2 = 32'd5;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
        end
        chk("flush_prestall", {31'd0, stall_request}, 32'd1);
        flush = 1'b1; #1;
        chk("flush_stall", {31'd0, stall_request}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; funct = 6'd0; #1;
        chk("flush_hi", hi, 32'h0000_1234);
        chk("flush_lo", lo, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        run_op("mult_after_flush", FUNCT_MULT, 32'd5, 32'd5, 32'd0, 32'd25);

        // MTLO suppressed by a simultaneous flush, then a plain MTLO.
        funct = FUNCT_MTLO; operand_1 = 32'h0000_ABCD; flush = 1'b1;
        @(posedge clk); #1;
        chk("mtlo_flush_lo", lo, 32'd25);
        flush = 1'b0;
        @(posedge clk); #1;
        chk("mtlo_lo", lo, 32'h0000_ABCD);
        funct = 6'd0;
        @(posedge clk); #1;

        // Reset in the middle of a DIVU.
        funct = FUNCT_DIVU; operand_1 = 32'd1000; operand_2 = 32'd3;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_stall", {31'd0, stall_request}, 32'd0);
        rst = 1'b0; funct = 6'd0;
        @(posedge clk); #1;
        chk("rst_after_stall", {31'd0, stall_request}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
